decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
Registered successor to the combinational main decoder. It decodes each fetched MIPS32 instruction into a packed control word and an exception code, then buffers the result in a DEPTH-entry circular queue. The queue sits between fetch and issue, with valid/ready handshakes on both sides and a flush input driven by the exception/branch-redirect logic. Decoded results also carry precise exception classification (RI, syscall, break, eret, fetch address error), which the previous decoder did not produce.

Parameters:
DEPTH, 4, number of queue entries; power of 2, minimum 2.
PTR_W, $clog2(DEPTH), queue pointer width; derived, not overridden.

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
flush  in  1  discard all entries and any same-cycle push
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept; equals (count < DEPTH); no combinational path from out_ready
in_instr  in  32  instruction word
in_pc  in  32  instruction PC
in_adel  in  1  fetch address error on this PC
out_valid  out  1  head entry valid; equals (count != 0)
out_ready  in  1  issue consumes the head
out_instr  out  32  head instruction
out_pc  out  32  head PC
out_ctrl  out  CTRL_W  head control word (see package)
out_eret  out  1  head is ERET (0x42000018)
out_excode  out  5  head exception code; 0 = none
count  out  PTR_W+1  current occupancy

Behaviour:
- Reset (resetn=0, asynchronous): head/tail pointers=0, count=0, all storage=0. Consequently out_valid=0, in_ready=1, out_* outputs=0.
- Decode is combinational on in_instr. The result is written to storage on push (in_valid & in_ready & ~flush). Latency: an instruction accepted in cycle N is visible at out_* in cycle N+1.
- Pop on out_valid & out_ready & ~flush. The head pointer increments modulo DEPTH; tail likewise on push. Pointers wrap naturally (power-of-2 depth).
- Simultaneous push and pop: count unchanged, both pointers advance. When full, no push (in_ready=0), even if a pop occurs the same cycle.
- Empty: out_valid=0, and out_* show stale storage, which the consumer ignores. Pop is ignored when empty.
- flush=1: next cycle count=0 and head=tail=0. A same-cycle push and a same-cycle pop are both discarded. Flush has priority over everything except reset.
- Control fields:
  - memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump, regjump, link, hilowrite, memsignext, memsize[1:0], cp0write, cp0toreg.
  - Semantics are identical to the existing decoder for the whole supported set: R-type ALU/shift/HI-LO/JR/JALR/SYSCALL/BREAK, I-type ALU, loads/stores (B/H/W), branches incl. REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL, J/JAL, MFC0/MTC0, ERET.
- Exception priority, highest first:
  - in_adel → 0x04
  - RI → 0x0a
  - SYSCALL → 0x08
  - BREAK → 0x09
- When excode != 0, regwrite, memwrite, hilowrite, cp0write, branch and jump are forced to 0 in the stored word. out_eret is stored unmodified.
- ERET is not RI. Any other COP0 rs encoding is RI.
- Mid-operation reset: immediate clear, regardless of handshake state.

Optional Feature:
- Macro DECODE_SPECIAL2_MUL_EN.
- Defined: op 011100 funct 000010 (MUL rd,rs,rt) decodes as regdst=1, regwrite=1, hilowrite=0, RI=0, and sets ctrl bit is_mul.
- Undefined: that encoding raises RI (excode 0x0a), and is_mul is tied 0.
- CTRL_W is the same in both builds.

Decomposition:
- Package decode_pkg:
  - CTRL_W=17 and the control-word bit-index constants (incl. is_mul).
  - excode constants EXC_ADEL/EXC_RI/EXC_SYS/EXC_BP.
  - MEM_BYTE/HALFWORD/WORD.
  - Opcode/funct/rs/rt constants from defines.vh/defines2.vh.
- One sub-module: decode_ctrl. It is purely combinational and maps instr and adel to ctrl, eret and excode. The queue and pointer logic live in decode_queue.

Test Plan:
- Push 0x24010005 (addiu $1,$0,5), out_ready=1 → next cycle out_valid=1, regwrite=1, alusrc=1, regdst=0, excode=0; count returns to 0.
- out_ready=0, push 5 instructions back-to-back → in_ready drops after the 4th; count=4; 5th held. Then out_ready=1 → FIFO order and PCs preserved across pointer wrap.
- Push 0xFC000000 → excode=0x0a, regwrite=0. Push 0x0000000C → excode=0x08. Push 0x0000000D → excode=0x09. in_adel=1 with 0x0000000C → excode=0x04.
- Queue count=3, assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0; the flushed-cycle instruction never appears.
- Push 0x42000018 → out_eret=1, excode=0. Push 0x40816000 (mtc0) → cp0write=1, regdst=1. Push 0x40016000 (mfc0) → cp0toreg=1, regwrite=1.
- 0x70221002 → with DECODE_SPECIAL2_MUL_EN: is_mul=1, regwrite=1, excode=0; without it: excode=0x0a. Separately, assert resetn=0 mid-stream with count=2 → outputs clear immediately (asynchronous reset).

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: control-word layout, exception codes, MIPS32 opcode fields, queue entry.
// The DECODE_SPECIAL2_MUL_EN build keeps the same CTRL_W; only the decoding of MUL changes.
package decode_pkg;

   localparam int unsigned CTRL_W = 17;
   localparam int unsigned EXC_W  = 5;

   // Control-word bit positions
   localparam int unsigned CTRL_MEMTOREG   = 0;
   localparam int unsigned CTRL_MEMWRITE   = 1;
   localparam int unsigned CTRL_BRANCH     = 2;
   localparam int unsigned CTRL_ALUSRC     = 3;
   localparam int unsigned CTRL_REGDST     = 4;
   localparam int unsigned CTRL_REGWRITE   = 5;
   localparam int unsigned CTRL_JUMP       = 6;
   localparam int unsigned CTRL_REGJUMP    = 7;
   localparam int unsigned CTRL_LINK       = 8;
   localparam int unsigned CTRL_HILOWRITE  = 9;
   localparam int unsigned CTRL_MEMSIGNEXT = 10;
   localparam int unsigned CTRL_MEMSIZE    = 11;  // two bits: 12:11
   localparam int unsigned CTRL_CP0WRITE   = 13;
   localparam int unsigned CTRL_CP0TOREG   = 14;
   localparam int unsigned CTRL_IS_MUL     = 15;
   localparam int unsigned CTRL_RSVD       = 16;  // spare, always 0

   localparam logic [EXC_W-1:0] EXC_NONE = 5'h00;
   localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;
   localparam logic [EXC_W-1:0] EXC_SYS  = 5'h08;
   localparam logic [EXC_W-1:0] EXC_BP   = 5'h09;
   localparam logic [EXC_W-1:0] EXC_RI   = 5'h0a;

   localparam logic [1:0] MEM_BYTE     = 2'd0;
   localparam logic [1:0] MEM_HALFWORD = 2'd1;
   localparam logic [1:0] MEM_WORD     = 2'd2;

   // Primary opcodes
   localparam logic [5:0] OP_SPECIAL  = 6'h00;
   localparam logic [5:0] OP_REGIMM   = 6'h01;
   localparam logic [5:0] OP_J        = 6'h02;
   localparam logic [5:0] OP_JAL      = 6'h03;
   localparam logic [5:0] OP_BEQ      = 6'h04;
   localparam logic [5:0] OP_BNE      = 6'h05;
   localparam logic [5:0] OP_BLEZ     = 6'h06;
   localparam logic [5:0] OP_BGTZ     = 6'h07;
   localparam logic [5:0] OP_ADDI     = 6'h08;
   localparam logic [5:0] OP_ADDIU    = 6'h09;
   localparam logic [5:0] OP_SLTI     = 6'h0a;
   localparam logic [5:0] OP_SLTIU    = 6'h0b;
   localparam logic [5:0] OP_ANDI     = 6'h0c;
   localparam logic [5:0] OP_ORI      = 6'h0d;
   localparam logic [5:0] OP_XORI     = 6'h0e;
   localparam logic [5:0] OP_LUI      = 6'h0f;
   localparam logic [5:0] OP_COP0     = 6'h10;
   localparam logic [5:0] OP_SPECIAL2 = 6'h1c;
   localparam logic [5:0] OP_LB       = 6'h20;
   localparam logic [5:0] OP_LH       = 6'h21;
   localparam logic [5:0] OP_LW       = 6'h23;
   localparam logic [5:0] OP_LBU      = 6'h24;
   localparam logic [5:0] OP_LHU      = 6'h25;
   localparam logic [5:0] OP_SB       = 6'h28;
   localparam logic [5:0] OP_SH       = 6'h29;
   localparam logic [5:0] OP_SW       = 6'h2b;

   // SPECIAL funct codes
   localparam logic [5:0] F_SLL     = 6'h00;
   localparam logic [5:0] F_SRL     = 6'h02;
   localparam logic [5:0] F_SRA     = 6'h03;
   localparam logic [5:0] F_SLLV    = 6'h04;
   localparam logic [5:0] F_SRLV    = 6'h06;
   localparam logic [5:0] F_SRAV    = 6'h07;
   localparam logic [5:0] F_JR      = 6'h08;
   localparam logic [5:0] F_JALR    = 6'h09;
   localparam logic [5:0] F_SYSCALL = 6'h0c;
   localparam logic [5:0] F_BREAK   = 6'h0d;
   localparam logic [5:0] F_MFHI    = 6'h10;
   localparam logic [5:0] F_MTHI    = 6'h11;
   localparam logic [5:0] F_MFLO    = 6'h12;
   localparam logic [5:0] F_MTLO    = 6'h13;
   localparam logic [5:0] F_MULT    = 6'h18;
   localparam logic [5:0] F_MULTU   = 6'h19;
   localparam logic [5:0] F_DIV     = 6'h1a;
   localparam logic [5:0] F_DIVU    = 6'h1b;
   localparam logic [5:0] F_ADD     = 6'h20;
   localparam logic [5:0] F_ADDU    = 6'h21;
   localparam logic [5:0] F_SUB     = 6'h22;
   localparam logic [5:0] F_SUBU    = 6'h23;
   localparam logic [5:0] F_AND     = 6'h24;
   localparam logic [5:0] F_OR      = 6'h25;
   localparam logic [5:0] F_XOR     = 6'h26;
   localparam logic [5:0] F_NOR     = 6'h27;
   localparam logic [5:0] F_SLT     = 6'h2a;
   localparam logic [5:0] F_SLTU    = 6'h2b;
   localparam logic [5:0] F2_MUL    = 6'h02;

   // COP0 rs and REGIMM rt selectors
   localparam logic [4:0] RS_MF     = 5'h00;
   localparam logic [4:0] RS_MT     = 5'h04;
   localparam logic [4:0] RT_BLTZ   = 5'h00;
   localparam logic [4:0] RT_BGEZ   = 5'h01;
   localparam logic [4:0] RT_BLTZAL = 5'h10;
   localparam logic [4:0] RT_BGEZAL = 5'h11;

   localparam logic [31:0] INSTR_ERET = 32'h4200_0018;

   typedef struct packed {
      logic [31:0]       instr;
      logic [31:0]       pc;
      logic [CTRL_W-1:0] ctrl;
      logic              eret;
      logic [EXC_W-1:0]  excode;
   } entry_t;

endpackage

// File: rtl/decode_queue_decode_ctrl.sv
// Combinational MIPS32 main decoder producing control word, ERET flag and prioritised exception code.
// With DECODE_SPECIAL2_MUL_EN defined, SPECIAL2 MUL is decoded instead of raising RI.
module decode_ctrl
   import decode_pkg::*;
(
   input  logic [31:0]       instr,
   input  logic              adel,
   output logic [CTRL_W-1:0] ctrl_c,
   output logic              eret_c,
   output logic [EXC_W-1:0]  excode_c
);

   logic [5:0]        op;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [5:0]        funct;
   logic              is_eret;
   logic              ri;
   logic              sys;
   logic              bp;
   logic [CTRL_W-1:0] raw;
   logic [EXC_W-1:0]  exc;

   assign op      = instr[31:26];
   assign rs      = instr[25:21];
   assign rt      = instr[20:16];
   assign funct   = instr[5:0];
   assign is_eret = (instr == INSTR_ERET);

   // Raw control decode plus illegal/trap classification
   always_comb begin
      raw = '0;
      ri  = 1'b0;
      sys = 1'b0;
      bp  = 1'b0;
      case (op)
         OP_SPECIAL: begin
            case (funct)
               F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
               F_MFHI, F_MFLO,
               F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
               F_SLT, F_SLTU: begin
                  raw[CTRL_REGDST]   = 1'b1;
                  raw[CTRL_REGWRITE] = 1'b1;
               end
               F_JR: begin
                  raw[CTRL_JUMP]    = 1'b1;
                  raw[CTRL_REGJUMP] = 1'b1;
               end
               F_JALR: begin
                  raw[CTRL_JUMP]     = 1'b1;
                  raw[CTRL_REGJUMP]  = 1'b1;
                  raw[CTRL_LINK]     = 1'b1;
                  raw[CTRL_REGDST]   = 1'b1;
                  raw[CTRL_REGWRITE] = 1'b1;
               end
               F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU:
                  raw[CTRL_HILOWRITE] = 1'b1;
               F_SYSCALL: sys = 1'b1;
               F_BREAK:   bp  = 1'b1;
               default:   ri  = 1'b1;
            endcase
         end
         OP_REGIMM: begin
            case (rt)
               RT_BLTZ, RT_BGEZ: raw[CTRL_BRANCH] = 1'b1;
               RT_BLTZAL, RT_BGEZAL: begin
                  raw[CTRL_BRANCH]   = 1'b1;
                  raw[CTRL_LINK]     = 1'b1;
                  raw[CTRL_REGWRITE] = 1'b1;
               end
               default: ri = 1'b1;
            endcase
         end
         OP_J: raw[CTRL_JUMP] = 1'b1;
         OP_JAL: begin
            raw[CTRL_JUMP]     = 1'b1;
            raw[CTRL_LINK]     = 1'b1;
            raw[CTRL_REGWRITE] = 1'b1;
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: raw[CTRL_BRANCH] = 1'b1;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            raw[CTRL_ALUSRC]   = 1'b1;
            raw[CTRL_REGWRITE] = 1'b1;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            raw[CTRL_MEMTOREG] = 1'b1;
            raw[CTRL_ALUSRC]   = 1'b1;
            raw[CTRL_REGWRITE] = 1'b1;
            raw[CTRL_MEMSIGNEXT] = (op == OP_LB) || (op == OP_LH);
            if (op == OP_LB || op == OP_LBU)
               raw[CTRL_MEMSIZE +: 2] = MEM_BYTE;
            else if (op == OP_LH || op == OP_LHU)
               raw[CTRL_MEMSIZE +: 2] = MEM_HALFWORD;
            else
               raw[CTRL_MEMSIZE +: 2] = MEM_WORD;
         end
         OP_SB, OP_SH, OP_SW: begin
            raw[CTRL_MEMWRITE] = 1'b1;
            raw[CTRL_ALUSRC]   = 1'b1;
            if (op == OP_SB)
               raw[CTRL_MEMSIZE +: 2] = MEM_BYTE;
            else if (op == OP_SH)
               raw[CTRL_MEMSIZE +: 2] = MEM_HALFWORD;
            else
               raw[CTRL_MEMSIZE +: 2] = MEM_WORD;
         end
         OP_COP0: begin
            // ERET carries no control bits; only MFC0/MTC0 and ERET are legal here
            if (!is_eret) begin
               case (rs)
                  RS_MF: begin
                     raw[CTRL_CP0TOREG] = 1'b1;
                     raw[CTRL_REGWRITE] = 1'b1;
                  end
                  RS_MT: begin
                     raw[CTRL_CP0WRITE] = 1'b1;
                     raw[CTRL_REGDST]   = 1'b1;
                  end
                  default: ri = 1'b1;
               endcase
            end
         end
`ifdef DECODE_SPECIAL2_MUL_EN
         OP_SPECIAL2: begin
            if (funct == F2_MUL) begin
               raw[CTRL_REGDST]   = 1'b1;
               raw[CTRL_REGWRITE] = 1'b1;
               raw[CTRL_IS_MUL]   = 1'b1;
            end else begin
               ri = 1'b1;
            end
         end
`else
         OP_SPECIAL2: ri = 1'b1;
`endif
         default: ri = 1'b1;
      endcase
   end

   // Exception priority and suppression of architectural side effects
   always_comb begin
      if (adel)
         exc = EXC_ADEL;
      else if (ri)
         exc = EXC_RI;
      else if (sys)
         exc = EXC_SYS;
      else if (bp)
         exc = EXC_BP;
      else
         exc = EXC_NONE;

      ctrl_c = raw;
      if (exc != EXC_NONE) begin
         ctrl_c[CTRL_REGWRITE]  = 1'b0;
         ctrl_c[CTRL_MEMWRITE]  = 1'b0;
         ctrl_c[CTRL_HILOWRITE] = 1'b0;
         ctrl_c[CTRL_CP0WRITE]  = 1'b0;
         ctrl_c[CTRL_BRANCH]    = 1'b0;
         ctrl_c[CTRL_JUMP]      = 1'b0;
      end
      ctrl_c[CTRL_RSVD] = 1'b0;
      eret_c   = is_eret;
      excode_c = exc;
   end

endmodule

// File: rtl/decode_queue.sv
// Decode-and-buffer stage: decodes each fetched instruction and holds it in a DEPTH-entry circular queue.
// Optional SPECIAL2 MUL decode is enabled by DECODE_SPECIAL2_MUL_EN (see decode_ctrl).
module decode_queue
   import decode_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [31:0]       in_pc,
   input  logic              in_adel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_eret,
   output logic [EXC_W-1:0]  out_excode,
   output logic [PTR_W:0]    count
);

   entry_t            mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic              push;
   logic              pop;
   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_eret;
   logic [EXC_W-1:0]  dec_excode;
   entry_t            wr_entry;

   decode_ctrl u_decode_ctrl (
      .instr    (in_instr),
      .adel     (in_adel),
      .ctrl_c   (dec_ctrl),
      .eret_c   (dec_eret),
      .excode_c (dec_excode)
   );

   // Handshake status comes only from the registered count, never from out_ready
   assign in_ready  = (count < (PTR_W+1)'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_comb begin
      wr_entry.instr  = in_instr;
      wr_entry.pc     = in_pc;
      wr_entry.ctrl   = dec_ctrl;
      wr_entry.eret   = dec_eret;
      wr_entry.excode = dec_excode;
   end

   // Pointers, occupancy and storage
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < int'(DEPTH); i++)
            mem[i] <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail] <= wr_entry;
            tail      <= tail + PTR_W'(1);
         end
         if (pop)
            head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Head entry is presented directly from storage; stale when empty
   assign out_instr  = mem[head].instr;
   assign out_pc     = mem[head].pc;
   assign out_ctrl   = mem[head].ctrl;
   assign out_eret   = mem[head].eret;
   assign out_excode = mem[head].excode;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: decode vector table, FIFO/full/flush sequences, async reset.
// Expectations for the MUL vector follow DECODE_SPECIAL2_MUL_EN.
module tb_decode_queue;
   import decode_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;
   localparam int NV = 22;

   logic              clk;
   logic              resetn;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [31:0]       in_pc;
   logic              in_adel;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [31:0]       out_pc;
   logic [CTRL_W-1:0] out_ctrl;
   logic              out_eret;
   logic [EXC_W-1:0]  out_excode;
   logic [PTR_W:0]    count;

   decode_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .in_adel    (in_adel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_pc     (out_pc),
      .out_ctrl   (out_ctrl),
      .out_eret   (out_eret),
      .out_excode (out_excode),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]       instr;
      logic              adel;
      logic [CTRL_W-1:0] ctrl;
      logic              eret;
      logic [EXC_W-1:0]  excode;
   } vec_t;

   vec_t   vecs [NV];
   entry_t model_q [$];
   entry_t cur_exp;
   int     errors = 0;
   int     checks = 0;

   function automatic logic [CTRL_W-1:0] b(input int unsigned idx);
      return CTRL_W'(1) << idx;
   endfunction

   function automatic logic [CTRL_W-1:0] msz(input logic [1:0] sz);
      return CTRL_W'(sz) << CTRL_MEMSIZE;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Check DUT against the scoreboard, then advance one clock and update the model
   task automatic cycle();
      logic push_m, pop_m;
      #2;
      chk("count", 64'(count), 64'(model_q.size()));
      chk("in_ready", 64'(in_ready), 64'(model_q.size() < int'(DEPTH)));
      chk("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
         chk("out_instr", 64'(out_instr), 64'(model_q[0].instr));
         chk("out_pc", 64'(out_pc), 64'(model_q[0].pc));
         chk("out_ctrl", 64'(out_ctrl), 64'(model_q[0].ctrl));
         chk("out_eret", 64'(out_eret), 64'(model_q[0].eret));
         chk("out_excode", 64'(out_excode), 64'(model_q[0].excode));
      end
      push_m = in_valid && (model_q.size() < int'(DEPTH)) && !flush;
      pop_m  = out_ready && (model_q.size() != 0) && !flush;
      @(posedge clk);
      if (flush) begin
         model_q.delete();
      end else begin
         if (pop_m)  void'(model_q.pop_front());
         if (push_m) model_q.push_back(cur_exp);
      end
      #1;
   endtask

   task automatic drive(input int i, input logic [31:0] pc);
      in_valid        = 1'b1;
      in_instr        = vecs[i].instr;
      in_pc           = pc;
      in_adel         = vecs[i].adel;
      cur_exp.instr   = vecs[i].instr;
      cur_exp.pc      = pc;
      cur_exp.ctrl    = vecs[i].ctrl;
      cur_exp.eret    = vecs[i].eret;
      cur_exp.excode  = vecs[i].excode;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_instr = 32'h0;
      in_pc    = 32'h0;
      in_adel  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{32'h24010005, 1'b0, b(CTRL_ALUSRC) | b(CTRL_REGWRITE), 1'b0, EXC_NONE};
      vecs[1]  = '{32'h00221820, 1'b0, b(CTRL_REGDST) | b(CTRL_REGWRITE), 1'b0, EXC_NONE};
      vecs[2]  = '{32'h8C430004, 1'b0, b(CTRL_MEMTOREG) | b(CTRL_ALUSRC) | b(CTRL_REGWRITE) | msz(MEM_WORD), 1'b0, EXC_NONE};
      vecs[3]  = '{32'hAC430008, 1'b0, b(CTRL_MEMWRITE) | b(CTRL_ALUSRC) | msz(MEM_WORD), 1'b0, EXC_NONE};
      vecs[4]  = '{32'h10220003, 1'b0, b(CTRL_BRANCH), 1'b0, EXC_NONE};
      vecs[5]  = '{32'hFC000000, 1'b0, '0, 1'b0, EXC_RI};
      vecs[6]  = '{32'h0000000C, 1'b0, '0, 1'b0, EXC_SYS};
      vecs[7]  = '{32'h0000000D, 1'b0, '0, 1'b0, EXC_BP};
      vecs[8]  = '{32'h0000000C, 1'b1, '0, 1'b0, EXC_ADEL};
      vecs[9]  = '{32'h42000018, 1'b0, '0, 1'b1, EXC_NONE};
      vecs[10] = '{32'h40816000, 1'b0, b(CTRL_CP0WRITE) | b(CTRL_REGDST), 1'b0, EXC_NONE};
      vecs[11] = '{32'h40016000, 1'b0, b(CTRL_CP0TOREG) | b(CTRL_REGWRITE), 1'b0, EXC_NONE};
`ifdef DECODE_SPECIAL2_MUL_EN
      vecs[12] = '{32'h70221002, 1'b0, b(CTRL_REGDST) | b(CTRL_REGWRITE) | b(CTRL_IS_MUL), 1'b0, EXC_NONE};
`else
      vecs[12] = '{32'h70221002, 1'b0, '0, 1'b0, EXC_RI};
`endif
      vecs[13] = '{32'h0C000010, 1'b0, b(CTRL_JUMP) | b(CTRL_LINK) | b(CTRL_REGWRITE), 1'b0, EXC_NONE};
      vecs[14] = '{32'h04110002, 1'b0, b(CTRL_BRANCH) | b(CTRL_LINK) | b(CTRL_REGWRITE), 1'b0, EXC_NONE};
      vecs[15] = '{32'h80430001, 1'b0, b(CTRL_MEMTOREG) | b(CTRL_ALUSRC) | b(CTRL_REGWRITE) | b(CTRL_MEMSIGNEXT) | msz(MEM_BYTE), 1'b0, EXC_NONE};
      vecs[16] = '{32'h0060F809, 1'b0, b(CTRL_JUMP) | b(CTRL_REGJUMP) | b(CTRL_LINK) | b(CTRL_REGDST) | b(CTRL_REGWRITE), 1'b0, EXC_NONE};
      vecs[17] = '{32'h00220018, 1'b0, b(CTRL_HILOWRITE), 1'b0, EXC_NONE};
      vecs[18] = '{32'h24010005, 1'b1, b(CTRL_ALUSRC), 1'b0, EXC_ADEL};
      vecs[19] = '{32'h42000018, 1'b1, '0, 1'b1, EXC_ADEL};
      vecs[20] = '{32'h44000000, 1'b0, '0, 1'b0, EXC_RI};
      vecs[21] = '{32'h40A00000, 1'b0, '0, 1'b0, EXC_RI};

      resetn    = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      idle();
      cur_exp   = '0;

      // Reset state
      #12;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      chk("rst_out_excode", 64'(out_excode), 64'd0);
      chk("rst_out_eret", 64'(out_eret), 64'd0);
      #5 resetn = 1'b1;
      @(posedge clk);
      #1;

      // Decode table: push one, see it next cycle, pop it
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(i, 32'h0000_1000 + 32'(4 * i));
         cycle();
         idle();
         cycle();
      end

      // Fill to full with a 5th held off, then drain across pointer wrap
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(i, 32'h0000_2000 + 32'(4 * i));
         cycle();
      end
      out_ready = 1'b1;
      cycle();
      cycle();
      idle();
      for (int i = 0; i < 5; i++) cycle();

      // Flush with same-cycle push and pop discards everything
      out_ready = 1'b0;
      for (int i = 1; i < 4; i++) begin
         drive(i, 32'h0000_3000 + 32'(4 * i));
         cycle();
      end
      drive(13, 32'h0000_3100);
      flush     = 1'b1;
      out_ready = 1'b1;
      cycle();
      flush = 1'b0;
      idle();
      cycle();
      cycle();
      drive(9, 32'h0000_3200);
      cycle();
      idle();
      cycle();
      cycle();

      // Asynchronous reset mid-stream with two entries queued
      out_ready = 1'b0;
      drive(10, 32'h0000_4000);
      cycle();
      drive(11, 32'h0000_4004);
      cycle();
      idle();
      chk("pre_rst_count", 64'(count), 64'd2);
      #3 resetn = 1'b0;
      #1;
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      chk("arst_out_instr", 64'(out_instr), 64'd0);
      chk("arst_out_pc", 64'(out_pc), 64'd0);
      chk("arst_out_ctrl", 64'(out_ctrl), 64'd0);
      model_q.delete();
      #2 resetn = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drive(0, 32'h0000_5000);
      cycle();
      idle();
      cycle();
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
